uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_tick.sv | 51 +++++
 rtl/uart_byte_rx.sv | 159 +++++++++++++++
 tb/tb_uart_byte_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud_set codes and the 16x divisor helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_e;

    function automatic int unsigned baud_rate(input logic [2:0] code);
        case (code)
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            BAUD_115200: return 115200;
            default:     return 9600;
        endcase
    endfunction

    // Clock cycles per oversample tick, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: selects the divisor from a baud code and pulses tick
// every DIV cycles; clear realigns the phase to a detected start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [2:0] baud_set,
    output logic       tick
);

    localparam int unsigned MAX_DIV = baud_div(CLK_FREQ, 9600);
    localparam int          CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_M1_9600   = CNT_W'(baud_div(CLK_FREQ, 9600) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_19200  = CNT_W'(baud_div(CLK_FREQ, 19200) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_38400  = CNT_W'(baud_div(CLK_FREQ, 38400) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_57600  = CNT_W'(baud_div(CLK_FREQ, 57600) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_115200 = CNT_W'(baud_div(CLK_FREQ, 115200) - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_m1;

    always_comb begin
        div_m1 = DIV_M1_9600;
        case (baud_set)
            BAUD_19200:  div_m1 = DIV_M1_19200;
            BAUD_38400:  div_m1 = DIV_M1_38400;
            BAUD_57600:  div_m1 = DIV_M1_57600;
            BAUD_115200: div_m1 = DIV_M1_115200;
            default:     div_m1 = DIV_M1_9600;
        endcase
    end

    // >= rather than == so a count left above a smaller divisor still wraps at once.
    assign tick = (cnt >= div_m1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 8 data bits LSB first, 16x oversampling with 7-sample majority vote.
// Define UART_RX_PARITY_EN to receive and check one even-parity bit after the data.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       uart_state,
    output rx_state_e  fsm_state
);

    rx_state_e  state, state_nxt;
    logic       sync1, sync2, hist;
    logic [2:0] baud_lat;
    logic       tick;
    logic [3:0] tick_idx;
    logic [2:0] ones;
    logic [2:0] ones_total;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       rx_done;

    logic start_edge, accept, sample_win, decide, bit_end, majority;

    assign start_edge = !sync2 && hist;
    assign accept     = start_edge && (state == IDLE);
    assign sample_win = tick && (tick_idx >= 4'd5) && (tick_idx <= 4'd11);
    assign decide     = tick && (tick_idx == 4'd11);
    assign bit_end    = tick && (tick_idx == 4'd15);
    // Count including the current sample so the decision can be made on tick 11 itself.
    assign ones_total = ones + {2'b00, sync2};
    assign majority   = (ones_total >= 3'd4);

    uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk      (Clk),
        .rst      (Rst),
        .clear    (accept),
        .baud_set (baud_lat),
        .tick     (tick)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = START;
            START: begin
                if (decide && majority) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) state_nxt = STOP;
`endif
            STOP:   if (decide) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            hist      <= 1'b1;
            baud_lat  <= BAUD_9600;
            tick_idx  <= 4'd0;
            ones      <= 3'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data_byte <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1   <= Rs232_Rx;
            sync2   <= sync1;
            hist    <= sync2;
            rx_done <= 1'b0;
            if (accept) begin
                baud_lat <= baud_set;
                tick_idx <= 4'd0;
                ones     <= 3'd0;
                bit_idx  <= 3'd0;
            end else if (tick && (state != IDLE)) begin
                tick_idx <= tick_idx + 4'd1;
                if (tick_idx == 4'd15) begin
                    ones <= 3'd0;
                end else if (sample_win) begin
                    ones <= ones_total;
                end
                if (bit_end && (state == DATA)) begin
                    bit_idx <= bit_idx + 3'd1;
                end
                if (decide) begin
                    case (state)
                        DATA: shift <= {majority, shift[7:1]};
`ifdef UART_RX_PARITY_EN
                        PARITY: par_bit <= majority;
`endif
                        STOP: begin
                            data_byte <= shift;
                            frame_err <= !majority;
                            rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= ^{shift, par_bit};
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign Rx_Done    = rx_done;
    assign uart_state = (state != IDLE) || rx_done;
    assign fsm_state  = state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed and randomized frames for uart_byte_rx, checked against a frame-level model.
// Parity expectations follow UART_RX_PARITY_EN when the bench is built with it.
module tb_uart_byte_rx;
    import uart_pkg::*;

    localparam int unsigned BENCH_CLK = 3_686_400;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rs232_Rx = 1'b1;
    logic [2:0] baud_set = 3'd0;
    logic [7:0] data_byte;
    logic       Rx_Done;
    logic       frame_err;
    logic       parity_err;
    logic       uart_state;
    rx_state_e  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {parity_err, frame_err, data}
    logic [9:0] exp_q[$];
    logic [9:0] rx_q[$];
    logic [7:0] last_data;

    uart_byte_rx #(.CLK_FREQ(BENCH_CLK)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rs232_Rx   (Rs232_Rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .uart_state (uart_state),
        .fsm_state  (fsm_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rx_Done === 1'b1) begin
            rx_q.push_back({parity_err, frame_err, data_byte});
            check("busy_at_done", 32'(uart_state), 32'd1);
        end
    end

    function automatic int bit_cycles(input int code);
        int rate;
        case (code)
            1:       rate = 19200;
            2:       rate = 38400;
            3:       rate = 57600;
            4:       rate = 115200;
            default: rate = 9600;
        endcase
        return 16 * int'(BENCH_CLK / (rate * 16));
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int bc);
        Rs232_Rx = v;
        wait_cycles(bc);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int code);
        int   bc;
        logic exp_par;
        bc = bit_cycles(code);
        baud_set = 3'(code);
        drive_bit(1'b0, bc);
        // A baud_set change mid-frame must not disturb the frame in flight.
        baud_set = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) begin
            Rs232_Rx = d[i];
            if (i == 0) begin
                wait_cycles(bc / 2);
                check("busy_mid_frame", 32'(uart_state), 32'd1);
                wait_cycles(bc - bc / 2);
            end else begin
                wait_cycles(bc);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(par, bc);
        exp_par = ^{d, par};
`else
        exp_par = 1'b0;
`endif
        drive_bit(stop, bc);
        exp_q.push_back({exp_par, ~stop, d});
        last_data = d;
    endtask

    task automatic check_rx(input string tag);
        logic [9:0] e, g;
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            g = rx_q.pop_front();
            check({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
            check({tag, "_frame_err"}, 32'(g[8]), 32'(e[8]));
            check({tag, "_parity_err"}, 32'(g[9]), 32'(e[9]));
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_byte"}, 32'(data_byte), 32'h00);
        check({tag, "_rx_done"}, 32'(Rx_Done), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_uart_state"}, 32'(uart_state), 32'd0);
        check({tag, "_fsm_idle"}, 32'(fsm_state), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] d;
        int         code;
        logic       stop;
        logic       par;
        int         bc;

        last_data = 8'h00;

        // Power-on reset.
        Rst = 1'b1;
        wait_cycles(4);
        check_reset_outputs("reset");
        Rst = 1'b0;
        wait_cycles(4);

        // 9600 baud, 0x7A, 8N1.
        send_frame(8'h7A, 1'b1, ^8'h7A, 0);
        wait_cycles(8);
        check_rx("frame_7a");
        check("held_7a", 32'(data_byte), 32'h7A);
        check("idle_after_7a", 32'(uart_state), 32'd0);

        // 115200 baud, back-to-back frames with one stop bit.
        send_frame(8'hA5, 1'b1, ^8'hA5, 4);
        send_frame(8'h3C, 1'b1, ^8'h3C, 4);
        wait_cycles(8);
        check_rx("b2b");

        // False start: line low for 3 tick periods at 115200.
        baud_set = 3'd4;
        Rs232_Rx = 1'b0;
        wait_cycles(3 * (bit_cycles(4) / 16));
        Rs232_Rx = 1'b1;
        wait_cycles(3 * bit_cycles(4));
        check_rx("false_start");
        check("false_start_idle", 32'(fsm_state), 32'(IDLE));
        check("false_start_data", 32'(data_byte), 32'(last_data));

        // 38400 baud, bad stop bit, then a good frame clears frame_err.
        send_frame(8'h55, 1'b0, ^8'h55, 2);
        Rs232_Rx = 1'b1;
        wait_cycles(bit_cycles(2));
        check("frame_err_held", 32'(frame_err), 32'd1);
        check_rx("bad_stop");
        send_frame(8'hC3, 1'b1, ^8'hC3, 2);
        wait_cycles(8);
        check_rx("after_bad_stop");
        check("frame_err_cleared", 32'(frame_err), 32'd0);

        // One-cycle reset at data bit 4 of an 0xFF frame.
        bc = bit_cycles(4);
        baud_set = 3'd4;
        drive_bit(1'b0, bc);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, bc);
        Rs232_Rx = 1'b1;
        wait_cycles(bc / 2);
        Rst = 1'b1;
        wait_cycles(1);
        Rst = 1'b0;
        check_reset_outputs("mid_reset");
        wait_cycles(bc - bc / 2 - 1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, bc);
        wait_cycles(2 * bc);
        check_rx("aborted");
        last_data = 8'h00;
        send_frame(8'h12, 1'b1, ^8'h12, 4);
        wait_cycles(8);
        check_rx("after_reset");

`ifdef UART_RX_PARITY_EN
        // Both parity bit values on the same data byte.
        send_frame(8'h7A, 1'b1, 1'b1, 4);
        wait_cycles(8);
        check_rx("parity_1");
        send_frame(8'h7A, 1'b1, 1'b0, 4);
        wait_cycles(8);
        check_rx("parity_0");
`endif

        // Randomized frames over all baud codes.
        for (int n = 0; n < 6; n++) begin
            d    = 8'($urandom);
            code = $urandom_range(0, 7);
            stop = ($urandom_range(0, 3) != 0);
            par  = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            send_frame(d, stop, par, code);
            Rs232_Rx = 1'b1;
            wait_cycles($urandom_range(2, 20));
            check_rx("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
